score_display: RTL and testbench

SCORE_DISPLAY -- requirements
Module: score_display

---
 rtl/score_display.sv | 155 +++++++++++++++
 tb/tb_score_display.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/score_display.sv
// Binary score to four-digit multiplexed seven-segment driver.
// Double-dabble conversion runs one bit per clk; outputs are registered.
module score_display #(
   parameter int SCORE_W  = 14,
   parameter int LZ_BLANK = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               digit_clk,
   input  logic [SCORE_W-1:0] score,
   input  logic               blank,
   output logic [3:0]         an,
   output logic [6:0]         seg,
   output logic               dp,
   output logic               bcd_valid
);

   localparam int MAXV = 9999;
   localparam int CW   = $clog2(SCORE_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

   state_e             state_q, state_d;
   logic [SCORE_W-1:0] sr_q, sr_d;
   logic [SCORE_W-1:0] val_q, val_d;
   logic [SCORE_W-1:0] last_q, last_d;
   logic [15:0]        bcd_q, bcd_d;
   logic [15:0]        disp_q, disp_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               valid_q, valid_d;
   logic               dclk_q, dclk_prev_q;
   logic [1:0]         idx_q;
   logic [3:0]         an_q, an_d;
   logic [6:0]         seg_q, seg_d;
   logic [SCORE_W-1:0] sat;
   logic [11:0]        adj;
   logic [3:0]         nib;
   logic               lz;
   logic               scan_step;

   assign scan_step = dclk_q & ~dclk_prev_q;

   always_comb begin
      sat = score;
      if (32'(score) > MAXV) sat = SCORE_W'(MAXV);
   end

   // Top nibble never reaches 5 before the final shift, so only three adjust.
   always_comb begin
      adj = '0;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         else                         adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      val_d   = val_q;
      last_d  = last_q;
      bcd_d   = bcd_q;
      disp_d  = disp_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      unique case (state_q)
         IDLE: begin
            if (sat != last_q) begin
               sr_d    = sat;
               val_d   = sat;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            bcd_d = {bcd_q[14:12], adj, sr_q[SCORE_W-1]};
            sr_d  = sr_q << 1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(SCORE_W - 1)) state_d = DONE;
         end
         DONE: begin
            disp_d  = bcd_q;
            last_d  = val_q;
            valid_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      nib = disp_q[{idx_q, 2'b00} +: 4];
      lz  = 1'b0;
      case (idx_q)
         2'd3:    lz = (disp_q[15:12] == 4'd0);
         2'd2:    lz = (disp_q[15:8] == 8'd0);
         2'd1:    lz = (disp_q[15:4] == 12'd0);
         default: lz = 1'b0;
      endcase
      an_d = 4'hF;
      if (!blank && !((LZ_BLANK != 0) && lz)) an_d[idx_q] = 1'b0;
      case (nib)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b1111111;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         val_q       <= '0;
         last_q      <= '0;
         bcd_q       <= '0;
         disp_q      <= '0;
         cnt_q       <= '0;
         valid_q     <= 1'b0;
         dclk_q      <= 1'b0;
         dclk_prev_q <= 1'b0;
         idx_q       <= 2'd0;
         an_q        <= 4'hF;
         seg_q       <= 7'h7F;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         val_q       <= val_d;
         last_q      <= last_d;
         bcd_q       <= bcd_d;
         disp_q      <= disp_d;
         cnt_q       <= cnt_d;
         valid_q     <= valid_d;
         dclk_q      <= digit_clk;
         dclk_prev_q <= dclk_q;
         if (scan_step) idx_q <= idx_q + 2'd1;
         an_q        <= an_d;
         seg_q       <= seg_d;
      end
   end

   assign an        = an_q;
   assign seg       = seg_q;
   assign dp        = 1'b1;
   assign bcd_valid = valid_q;

endmodule

// File: tb/tb_score_display.sv
// Directed and random checks of score_display against a decimal-digit model.
// Expected digits come from integer division of the saturated score.
module tb_score_display;

   logic        clk = 1'b0;
   logic        rst;
   logic        digit_clk;
   logic [13:0] score;
   logic        blank;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        bcd_valid;

   int checks   = 0;
   int failures = 0;
   int midx     = 0;

   logic [6:0] enc_t [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   score_display #(.SCORE_W(14), .LZ_BLANK(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .digit_clk (digit_clk),
      .score     (score),
      .blank     (blank),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .bcd_valid (bcd_valid)
   );

   always #5 clk = ~clk;

   function automatic int pow10(input int d);
      int p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
      return p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_now(input int v, input bit bl);
      int  s;
      int  dig;
      bit  shown;
      logic [3:0] exp_an;
      s      = (v > 9999) ? 9999 : v;
      dig    = (s / pow10(midx)) % 10;
      shown  = !bl && (midx == 0 || s >= pow10(midx));
      exp_an = 4'hF;
      if (shown) exp_an[midx] = 1'b0;
      chk($sformatf("an v=%0d d=%0d", v, midx), 32'(an), 32'(exp_an));
      if (shown)
         chk($sformatf("seg v=%0d d=%0d", v, midx), 32'(seg), 32'(enc_t[dig]));
      chk("dp", 32'(dp), 32'd1);
   endtask

   task automatic step();
      @(negedge clk) digit_clk = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      midx = (midx + 1) % 4;
   endtask

   task automatic scan(input int v, input bit bl);
      repeat (4) begin
         step();
         check_now(v, bl);
         @(negedge clk) digit_clk = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic wait_conv();
      repeat (20) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      bit got;
      int v;
      rst       = 1'b0;
      digit_clk = 1'b0;
      score     = '0;
      blank     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_dp", 32'(dp), 32'd1);
      chk("rst_valid", 32'(bcd_valid), 32'd0);

      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_now(0, 1'b0);
      scan(0, 1'b0);
      chk("valid_zero", 32'(bcd_valid), 32'd0);

      @(negedge clk) score = 14'd1234;
      n   = 0;
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(posedge clk);
         #1;
         if (bcd_valid) begin
            got = 1'b1;
            n   = i;
         end
      end
      chk("valid_latency", 32'(n), 32'd16);
      repeat (2) @(posedge clk);
      #1;
      scan(1234, 1'b0);

      @(negedge clk) score = 14'd12000;
      wait_conv();
      scan(12000, 1'b0);

      @(negedge clk) score = 14'd5;
      repeat (4) @(posedge clk);
      @(negedge clk) score = 14'd70;
      repeat (14) @(posedge clk);
      #1;
      check_now(5, 1'b0);
      repeat (16) @(posedge clk);
      #1;
      check_now(70, 1'b0);
      scan(70, 1'b0);

      @(negedge clk) begin
         blank = 1'b1;
         score = 14'd8888;
      end
      wait_conv();
      scan(8888, 1'b1);
      @(negedge clk) blank = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_now(8888, 1'b0);

      for (int k = 0; k < 8; k++) begin
         v = int'($urandom_range(0, 16383));
         @(negedge clk) score = 14'(v);
         wait_conv();
         scan(v, 1'b0);
      end

      @(negedge clk) score = 14'd4321;
      repeat (8) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      midx = 0;
      chk("abort_an", 32'(an), 32'hF);
      chk("abort_seg", 32'(seg), 32'h7F);
      chk("abort_valid", 32'(bcd_valid), 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_now(0, 1'b0);
      chk("abort_valid_rel", 32'(bcd_valid), 32'd0);
      wait_conv();
      chk("reconv_valid", 32'(bcd_valid), 32'd1);
      scan(4321, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
